// File: rtl/servo_pkg.sv
// +----------------------------------------------------------------------------+
// | servo_pkg : register offsets, CTRL bit indices and FSM states for          |
// |             the servo_ramp block                                           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package servo_pkg;

   localparam logic [7:0] ADDR_TARGET  = 8'h00;
   localparam logic [7:0] ADDR_STEP    = 8'h04;
   localparam logic [7:0] ADDR_CURRENT = 8'h08;
   localparam logic [7:0] ADDR_CTRL    = 8'h0C;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_BUSY_BIT = 1;
   localparam int CTRL_DONE_BIT = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/servo_ramp_if.sv
// +----------------------------------------------------------------------------+
// | servo_ramp_if : APB slave bus bundle for servo_ramp                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface servo_ramp_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

`default_nettype wire

// File: rtl/servo_frame_timer.sv
// +----------------------------------------------------------------------------+
// | servo_frame_timer : free-running 0..PERIOD counter, tick on last cycle     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module servo_frame_timer #(
   parameter int PERIOD = 2000000
) (
   input  logic PCLK,
   input  logic PRESETN,
   output logic tick
);

   localparam int            CW   = (PERIOD < 1) ? 1 : $clog2(PERIOD + 1);
   localparam logic [CW-1:0] LAST = CW'(PERIOD);

   logic [CW-1:0] count;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/servo_ramp.sv
// +----------------------------------------------------------------------------+
// | servo_ramp : APB-programmed servo pulse-width ramp, one step per frame.    |
// | Optional build macro SERVO_RAMP_CLAMP_EN clamps TARGET to [MIN_PW,MAX_PW]. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module servo_ramp
   import servo_pkg::*;
#(
   parameter int PERIOD   = 2000000,
   parameter int MIN_PW   = 100000,
   parameter int MAX_PW   = 200000,
   parameter int RESET_PW = 150000
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   servo_ramp_if.slave apb,
   output logic [31:0] pulse_width,
   output logic        frame_tick,
   output logic        irq
);

   logic [31:0] target;
   logic [31:0] step;
   logic [31:0] current;
   logic        en;
   logic        done;
   state_t      state;
   state_t      state_d;
   logic [31:0] current_d;
   logic        done_set;
   logic [31:0] diff;
   logic [31:0] delta;
   logic [31:0] stepped;
   logic [31:0] target_wval;

   logic wr;
   logic wr_target;
   logic wr_step;
   logic wr_ctrl;

   servo_frame_timer #(
      .PERIOD (PERIOD)
   ) u_frame_timer (
      .PCLK    (PCLK),
      .PRESETN (PRESETN),
      .tick    (frame_tick)
   );

   assign wr        = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign wr_target = wr && (apb.PADDR == ADDR_TARGET);
   assign wr_step   = wr && (apb.PADDR == ADDR_STEP);
   assign wr_ctrl   = wr && (apb.PADDR == ADDR_CTRL);

`ifdef SERVO_RAMP_CLAMP_EN
   assign target_wval = (apb.PWDATA < 32'(MIN_PW)) ? 32'(MIN_PW) :
                        (apb.PWDATA > 32'(MAX_PW)) ? 32'(MAX_PW) : apb.PWDATA;
`else
   assign target_wval = apb.PWDATA;
`endif

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Step size is min(STEP, distance); STEP==0 collapses to the full distance.
   always_comb begin
      state_d   = state;
      current_d = current;
      done_set  = 1'b0;
      diff      = (target >= current) ? (target - current) : (current - target);
      delta     = ((step == 32'd0) || (step > diff)) ? diff : step;
      stepped   = (target >= current) ? (current + delta) : (current - delta);
      case (state)
         ST_IDLE: begin
            if (en && (target != current)) begin
               state_d = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (frame_tick && en) begin
               current_d = stepped;
               if (stepped == target) begin
                  state_d  = ST_IDLE;
                  done_set = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         target  <= 32'(RESET_PW);
         step    <= 32'd0;
         current <= 32'(RESET_PW);
         en      <= 1'b0;
         done    <= 1'b0;
      end else begin
         current <= current_d;
         if (wr_target) begin
            target <= target_wval;
         end
         if (wr_step) begin
            step <= apb.PWDATA;
         end
         if (wr_ctrl) begin
            en <= apb.PWDATA[CTRL_EN_BIT];
         end
         // A set in the same cycle as a W1C clear must win.
         if (done_set) begin
            done <= 1'b1;
         end else if (wr_ctrl && apb.PWDATA[CTRL_DONE_BIT]) begin
            done <= 1'b0;
         end
      end
   end

   always_comb begin
      apb.PRDATA = 32'd0;
      case (apb.PADDR)
         ADDR_TARGET:  apb.PRDATA = target;
         ADDR_STEP:    apb.PRDATA = step;
         ADDR_CURRENT: apb.PRDATA = current;
         ADDR_CTRL: begin
            apb.PRDATA[CTRL_EN_BIT]   = en;
            apb.PRDATA[CTRL_BUSY_BIT] = (state == ST_RAMP);
            apb.PRDATA[CTRL_DONE_BIT] = done;
         end
         default: apb.PRDATA = 32'd0;
      endcase
   end

   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = 1'b0;
   assign pulse_width = current;
   assign irq         = done;

endmodule

`default_nettype wire

// File: tb/tb_servo_ramp.sv
// +----------------------------------------------------------------------------+
// | tb_servo_ramp : directed self-checking bench for servo_ramp                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_servo_ramp;

   logic        PCLK;
   logic        PRESETN;
   logic [31:0] pulse_width;
   logic        frame_tick;
   logic        irq;
   int          total;
   int          bad;
   int          ncyc;

   servo_ramp_if bus ();

   servo_ramp #(
      .PERIOD   (99),
      .MIN_PW   (10),
      .MAX_PW   (90),
      .RESET_PW (50)
   ) dut (
      .PCLK        (PCLK),
      .PRESETN     (PRESETN),
      .apb         (bus),
      .pulse_width (pulse_width),
      .frame_tick  (frame_tick),
      .irq         (irq)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
      @(negedge PCLK);
      bus.PSEL    = 1'b1;
      bus.PWRITE  = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PADDR   = addr;
      bus.PWDATA  = data;
      @(negedge PCLK);
      bus.PENABLE = 1'b1;
      @(negedge PCLK);
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
   endtask

   task automatic apb_read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      bus.PADDR = addr;
      #1;
      check(tag, bus.PRDATA, exp);
   endtask

   task automatic wait_negs(input int n);
      for (int i = 0; i < n; i++) @(negedge PCLK);
   endtask

   // Returns at the negedge where frame_tick is high.
   task automatic sync_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge PCLK);
         if (frame_tick) seen = 1'b1;
      end
      if (!seen) check("tick_timeout", 32'd0, 32'd1);
   endtask

   // Returns just after the rising edge that consumes the next frame_tick.
   task automatic wait_tick();
      sync_tick();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = 8'h00;
      bus.PWDATA  = 32'd0;
      PRESETN     = 1'b0;

      // Reset state
      wait_negs(3);
      check("rst_pw", pulse_width, 32'd50);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      PRESETN = 1'b1;
      apb_read_check("rst_ctrl", 8'h0C, 32'd0);
      apb_read_check("rst_target", 8'h00, 32'd50);
      apb_read_check("rst_current", 8'h08, 32'd50);
      apb_read_check("unmapped", 8'h10, 32'd0);

      // Frame period
      sync_tick();
      ncyc = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge PCLK);
         ncyc++;
         if (frame_tick) break;
      end
      check("frame_period", ncyc, 32'd100);

      // Ramp up by 7
      apb_write(8'h04, 32'd7);
      apb_write(8'h00, 32'd71);
      apb_write(8'h08, 32'd1234);
      apb_write(8'h0C, 32'd1);
      @(negedge PCLK);
      apb_read_check("ramp_busy", 8'h0C, 32'd3);
      apb_read_check("cur_ro", 8'h08, 32'd50);
      wait_tick();
      check("ramp_t1", pulse_width, 32'd57);
      wait_tick();
      check("ramp_t2", pulse_width, 32'd64);
      apb_read_check("ramp_t2_ctrl", 8'h0C, 32'd3);
      wait_tick();
      check("ramp_t3", pulse_width, 32'd71);
      apb_read_check("ramp_done_ctrl", 8'h0C, 32'd5);
      check("ramp_irq", {31'd0, irq}, 32'd1);

      // Jump with STEP=0, then W1C
      apb_write(8'h04, 32'd0);
      apb_write(8'h00, 32'd20);
      wait_tick();
      check("jump_pw", pulse_width, 32'd20);
      apb_write(8'h0C, 32'd4);
      check("w1c_irq", {31'd0, irq}, 32'd0);
      apb_read_check("w1c_ctrl", 8'h0C, 32'd0);

      // Freeze with EN=0 mid-ramp
      apb_write(8'h04, 32'd22);
      apb_write(8'h00, 32'd71);
      apb_write(8'h0C, 32'd1);
      wait_tick();
      check("frz_t1", pulse_width, 32'd42);
      wait_tick();
      check("frz_t2", pulse_width, 32'd64);
      apb_write(8'h0C, 32'd0);
      apb_read_check("frz_ctrl", 8'h0C, 32'd2);
      for (int k = 0; k < 3; k++) begin
         wait_tick();
         check("frz_hold", pulse_width, 32'd64);
      end
      apb_write(8'h0C, 32'd1);
      wait_tick();
      check("frz_resume", pulse_width, 32'd71);
      apb_read_check("frz_done", 8'h0C, 32'd5);

      // DONE set coincident with W1C clear: set wins
      apb_write(8'h0C, 32'd5);
      check("clr_before", {31'd0, irq}, 32'd0);
      sync_tick();
      apb_write(8'h04, 32'd0);
      apb_write(8'h00, 32'd60);
      wait_negs(92);
      apb_write(8'h0C, 32'd5);
      check("setwin_pw", pulse_width, 32'd60);
      check("setwin_irq", {31'd0, irq}, 32'd1);

      // TARGET write coincident with tick uses old TARGET
      apb_write(8'h04, 32'd5);
      apb_write(8'h00, 32'd70);
      wait_negs(91);
      apb_write(8'h00, 32'd40);
      check("coinc_old", pulse_width, 32'd65);
      wait_tick();
      check("coinc_new", pulse_width, 32'd60);

      // Retarget to CURRENT during RAMP
      apb_write(8'h0C, 32'd5);
      apb_write(8'h00, 32'd60);
      apb_read_check("retgt_busy", 8'h0C, 32'd3);
      wait_tick();
      check("retgt_pw", pulse_width, 32'd60);
      apb_read_check("retgt_ctrl", 8'h0C, 32'd5);

      // Clamp option
      apb_write(8'h0C, 32'd4);
      apb_write(8'h00, 32'd200);
`ifdef SERVO_RAMP_CLAMP_EN
      apb_read_check("clamp_hi", 8'h00, 32'd90);
`else
      apb_read_check("clamp_hi", 8'h00, 32'd200);
`endif

      // Reset mid-ramp
      apb_write(8'h0C, 32'd1);
      wait_tick();
      check("pre_rst_pw", pulse_width, 32'd65);
      #5;
      PRESETN = 1'b0;
      #1;
      check("async_rst_pw", pulse_width, 32'd50);
      check("async_rst_irq", {31'd0, irq}, 32'd0);
      @(negedge PCLK);
      PRESETN = 1'b1;
      apb_read_check("post_rst_ctrl", 8'h0C, 32'd0);
      apb_read_check("post_rst_target", 8'h00, 32'd50);
      apb_read_check("post_rst_step", 8'h04, 32'd0);
      wait_tick();
      check("post_rst_hold", pulse_width, 32'd50);
      check("post_rst_irq", {31'd0, irq}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
